fb_scanout: RTL and testbench

Display-side read controller for the frame buffer. It sits directly downstream of the `data_mem_alt` frame-buffer memory. It generates the raster timing (h/v counters, hsync, vsync, data-enable) and drives the memory's `rd_en`/`rd_addr` one pixel per clock in raster order. It then realigns the returned `rd_data` with the delayed sync signals to form a pixel stream for the display encoder.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_timing_gen.sv | 75 +++++++
 rtl/fb_scanout.sv | 166 ++++++++++++++++
 tb/tb_fb_scanout.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer scanout path: default VGA 640x480
// raster timing, default sync polarity and the scanout FSM encoding.
package fb_pkg;

    localparam int   FB_DATA_WIDTH = 16;
    localparam int   FB_ADDR_WIDTH = 19;
    localparam int   FB_H_ACTIVE   = 640;
    localparam int   FB_H_FP       = 16;
    localparam int   FB_H_SYNC     = 96;
    localparam int   FB_H_BP       = 48;
    localparam int   FB_V_ACTIVE   = 480;
    localparam int   FB_V_FP       = 10;
    localparam int   FB_V_SYNC     = 2;
    localparam int   FB_V_BP       = 33;
    localparam logic FB_SYNC_POL   = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fb_state_t;

endpackage

// File: rtl/fb_timing_gen.sv
// Raster timing generator: free-running h/v counters while run is high,
// cleared to the frame origin otherwise; decodes active, sync and boundary flags.
module fb_timing_gen
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = FB_H_ACTIVE,
    parameter int H_FP     = FB_H_FP,
    parameter int H_SYNC   = FB_H_SYNC,
    parameter int H_BP     = FB_H_BP,
    parameter int V_ACTIVE = FB_V_ACTIVE,
    parameter int V_FP     = FB_V_FP,
    parameter int V_SYNC   = FB_V_SYNC,
    parameter int V_BP     = FB_V_BP
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic active,
    output logic hsync_act,
    output logic vsync_act,
    output logic frame_bound
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VCW     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);

    // Window bounds kept at 32 bits so an end equal to the total cannot wrap.
    localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
    localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
    localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCW-1:0] h_cnt_r;
    logic [VCW-1:0] v_cnt_r;
    logic [31:0]    h_ext_s;
    logic [31:0]    v_ext_s;

    // Horizontal and vertical position counters; v advances on h wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_r <= {HCW{1'b0}};
            v_cnt_r <= {VCW{1'b0}};
        end else if (!run) begin
            h_cnt_r <= {HCW{1'b0}};
            v_cnt_r <= {VCW{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= {HCW{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= {VCW{1'b0}};
            end else begin
                v_cnt_r <= v_cnt_r + VCW'(1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + HCW'(1);
        end
    end

    // Region decode from the current counter state.
    always_comb begin
        h_ext_s     = 32'(h_cnt_r);
        v_ext_s     = 32'(v_cnt_r);
        active      = (h_ext_s < H_ACT_END) && (v_ext_s < V_ACT_END);
        hsync_act   = (h_ext_s >= H_SYNC_BEG) && (h_ext_s < H_SYNC_END);
        vsync_act   = (v_ext_s >= V_SYNC_BEG) && (v_ext_s < V_SYNC_END);
        frame_bound = (h_cnt_r == {HCW{1'b0}}) && (v_cnt_r == {VCW{1'b0}});
    end

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: raster FSM, linear read pointer and a pipeline that
// realigns memory read data with delayed sync/DE/frame-start flags.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int   DATA_WIDTH = FB_DATA_WIDTH,
    parameter int   ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int   H_ACTIVE   = FB_H_ACTIVE,
    parameter int   H_FP       = FB_H_FP,
    parameter int   H_SYNC     = FB_H_SYNC,
    parameter int   H_BP       = FB_H_BP,
    parameter int   V_ACTIVE   = FB_V_ACTIVE,
    parameter int   V_FP       = FB_V_FP,
    parameter int   V_SYNC     = FB_V_SYNC,
    parameter int   V_BP       = FB_V_BP,
    parameter logic SYNC_POL   = FB_SYNC_POL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);

    fb_state_t             state_r;
    logic                  run_s;
    logic                  active_s;
    logic                  hsync_act_s;
    logic                  vsync_act_s;
    logic                  frame_bound_s;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH-1:0] ptr_s;
    logic                  hs_a_r;
    logic                  vs_a_r;
    logic                  fs_a_r;
    logic                  de_b_r;
    logic                  hs_b_r;
    logic                  vs_b_r;
    logic                  fs_b_r;

    fb_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .run         (run_s),
        .active      (active_s),
        .hsync_act   (hsync_act_s),
        .vsync_act   (vsync_act_s),
        .frame_bound (frame_bound_s)
    );

    // Counters advance in RUN unless en is found low at a frame boundary.
    // At the boundary the new base is used directly as the first address.
    always_comb begin
        if (state_r == ST_RUN) begin
            run_s = en || !frame_bound_s;
        end else begin
            run_s = 1'b0;
        end
        if (frame_bound_s) begin
            ptr_s = frame_base;
        end else begin
            ptr_s = ptr_r;
        end
    end

    // Scanout FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (run_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Read request stage: one address per active pixel, flags captured alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en   <= 1'b0;
            rd_addr <= {ADDR_WIDTH{1'b0}};
            ptr_r   <= {ADDR_WIDTH{1'b0}};
            hs_a_r  <= 1'b0;
            vs_a_r  <= 1'b0;
            fs_a_r  <= 1'b0;
        end else begin
            if (run_s && active_s) begin
                rd_en   <= 1'b1;
                rd_addr <= ptr_s;
                ptr_r   <= ptr_s + ADDR_WIDTH'(1);
            end else begin
                rd_en   <= 1'b0;
            end
            hs_a_r <= run_s && hsync_act_s;
            vs_a_r <= run_s && vsync_act_s;
            fs_a_r <= run_s && frame_bound_s;
        end
    end

    // Delay stage covering the memory's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_b_r <= 1'b0;
            hs_b_r <= 1'b0;
            vs_b_r <= 1'b0;
            fs_b_r <= 1'b0;
        end else begin
            de_b_r <= rd_en;
            hs_b_r <= hs_a_r;
            vs_b_r <= vs_a_r;
            fs_b_r <= fs_a_r;
        end
    end

    // Output stage: data blanked outside DE, sync flags mapped to polarity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_data    <= {DATA_WIDTH{1'b0}};
            pix_de      <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            if (de_b_r) begin
                pix_data <= rd_data;
            end else begin
                pix_data <= {DATA_WIDTH{1'b0}};
            end
            pix_de      <= de_b_r;
            hsync       <= hs_b_r ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_b_r ? SYNC_POL : ~SYNC_POL;
            frame_start <= fs_b_r;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized bench for fb_scanout on a tiny 8x6 raster with a 16-entry memory;
// expected outputs come from a position-based raster model.
module tb_fb_scanout;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [AW-1:0] frame_base = 4'h0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = 16'h0000;
    logic [DW-1:0] pix_data;
    logic          pix_de;
    logic          hsync;
    logic          vsync;
    logic          frame_start;

    int n_checks = 0;
    int n_errors = 0;

    fb_scanout #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b0)
    ) dut (
        .clk (clk), .reset (reset), .en (en), .frame_base (frame_base),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
        .pix_data (pix_data), .pix_de (pix_de), .hsync (hsync),
        .vsync (vsync), .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Frame-buffer memory: content 0x100 + address, one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= 16'h0100 + {12'h000, rd_addr};
    end

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [DW-1:0] data;
    } ent_t;

    // Model: whether a frame is in progress, position within it, frame base.
    int            m_run;
    int            m_pos;
    int            m_base;
    logic [AW-1:0] exp_addr;
    ent_t          ent_a, ent_b, ent_c;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_pos    = 0;
        m_base   = 0;
        exp_addr = 4'h0;
        ent_a    = '0;
        ent_b    = '0;
        ent_c    = '0;
    endtask

    task automatic model_step();
        ent_t na;
        int   h, v;
        na = '0;
        if (m_run == 0) begin
            if (en) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (m_pos == 0 && !en) begin
            m_run = 0;
        end else begin
            if (m_pos == 0) m_base = int'(frame_base);
            h = m_pos % HT;
            v = m_pos / HT;
            na.de = (h < HA) && (v < VA);
            if (na.de) begin
                exp_addr = 4'((m_base + v * HA + h) % 16);
                na.data  = 16'h0100 + {12'h000, exp_addr};
            end
            na.hs = (h >= HA + HF) && (h < HA + HF + HS);
            na.vs = (v >= VA + VF) && (v < VA + VF + VS);
            na.fs = (m_pos == 0);
            m_pos = (m_pos + 1) % FT;
        end
        ent_c = ent_b;
        if (!ent_c.de) ent_c.data = 16'h0000;
        ent_b = ent_a;
        ent_a = na;
    endtask

    task automatic check_all();
        check_val("rd_en",       32'(rd_en),       32'(ent_a.de));
        check_val("rd_addr",     32'(rd_addr),     32'(exp_addr));
        check_val("pix_de",      32'(pix_de),      32'(ent_c.de));
        check_val("pix_data",    32'(pix_data),    32'(ent_c.data));
        check_val("hsync",       32'(hsync),       32'(!ent_c.hs));
        check_val("vsync",       32'(vsync),       32'(!ent_c.vs));
        check_val("frame_start", 32'(frame_start), 32'(ent_c.fs));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Asynchronous reset between clock edges, checked before the next edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
    endtask

    initial begin
        model_reset();
        run_cycles(3);
        reset = 1'b0;
        run_cycles(12);

        en = 1'b1;
        frame_base = 4'h0;
        run_cycles(2 * FT + 5);

        frame_base = 4'hE;
        run_cycles(2 * FT);

        // Mid-frame base change and en drop: frame finishes, then idle.
        run_cycles(10);
        frame_base = 4'h7;
        en = 1'b0;
        run_cycles(FT + 20);

        // Reset pulse mid-line, then restart at frame_base.
        en = 1'b1;
        frame_base = 4'h9;
        run_cycles(FT + 10);
        async_reset();
        run_cycles(2);
        reset = 1'b0;
        run_cycles(FT + 5);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 6) frame_base = 4'($urandom_range(0, 15));
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
